// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and the Memory block.
// Word accesses at odd addresses are split into two byte accesses when UNALIGNED_EN=1.
module load_store_unit #(
  parameter int ADDR_W       = 16,
  parameter bit UNALIGNED_EN = 1'b1
) (
  input  logic              C,
  input  logic              R,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [15:0]       resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_A,
  output logic [15:0]       mem_WW,
  output logic [7:0]        mem_WB,
  output logic [1:0]        mem_MW,
  input  logic [15:0]       mem_W,
  input  logic [7:0]        mem_B
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b011;
  localparam logic [2:0] OP_SB  = 3'b100;

  localparam logic [1:0] MW_RD = 2'b00;
  localparam logic [1:0] MW_SB = 2'b01;
  localparam logic [1:0] MW_SW = 2'b10;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, mem_a_d;
  logic [15:0]         wdata_q, wdata_d, ww_d, rdata_d;
  logic [7:0]          wb_d;
  logic [1:0]          mw_d;
  logic                rvalid_d, rerr_d;
  logic                req_word, req_unal;

  assign req_ready = (state == IDLE);
  assign req_word  = (req_op == OP_LW) || (req_op == OP_SW);
  assign req_unal  = req_word && req_addr[0];

  // Next-state and next-register values; mem_MW defaults to read so it can
  // only be non-zero in the cycle that actually drives a store.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mem_a_d  = mem_A;
    ww_d     = mem_WW;
    wb_d     = mem_WB;
    mw_d     = MW_RD;
    rvalid_d = resp_valid;
    rdata_d  = resp_data;
    rerr_d   = resp_err;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 16'h0000;
          if (req_op > OP_SB || (req_unal && !UNALIGNED_EN)) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
          end else begin
            state_d = ACC1;
            rerr_d  = 1'b0;
            mem_a_d = req_addr;
            if (req_op == OP_SW && !req_unal) begin
              mw_d = MW_SW;
              ww_d = req_wdata;
            end else if (req_op == OP_SW || req_op == OP_SB) begin
              mw_d = MW_SB;
              wb_d = req_wdata[7:0];
            end
          end
        end
      end
      ACC1: begin
        state_d  = RESP;
        rvalid_d = 1'b1;
        unique case (op_q)
          OP_LW:   rdata_d = addr_q[0] ? {8'h00, mem_B} : mem_W;
          OP_LB:   rdata_d = {{8{mem_B[7]}}, mem_B};
          OP_LBU:  rdata_d = {8'h00, mem_B};
          default: rdata_d = 16'h0000;
        endcase
        if ((op_q == OP_LW || op_q == OP_SW) && addr_q[0]) begin
          state_d  = ACC2;
          rvalid_d = 1'b0;
          mem_a_d  = addr_q + ONE;
          if (op_q == OP_SW) begin
            mw_d = MW_SB;
            wb_d = wdata_q[15:8];
          end
        end
      end
      ACC2: begin
        state_d  = RESP;
        rvalid_d = 1'b1;
        if (op_q == OP_LW) rdata_d = {mem_B, resp_data[7:0]};
      end
      RESP: begin
        if (resp_ready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset clears mem_MW asynchronously, so an interrupted store never commits.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state      <= IDLE;
      op_q       <= OP_LW;
      addr_q     <= '0;
      wdata_q    <= 16'h0000;
      mem_A      <= '0;
      mem_WW     <= 16'h0000;
      mem_WB     <= 8'h00;
      mem_MW     <= MW_RD;
      resp_valid <= 1'b0;
      resp_data  <= 16'h0000;
      resp_err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state      <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_A      <= mem_a_d;
      mem_WW     <= ww_d;
      mem_WB     <= wb_d;
      mem_MW     <= mw_d;
      resp_valid <= rvalid_d;
      resp_data  <= rdata_d;
      resp_err   <= rerr_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory model, directed cases, then
// random ops checked against an abstract reference memory.
module tb_load_store_unit;

  localparam bit UNALIGNED_EN = 1'b1;

  logic        C, R;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [2:0]  req_op;
  logic [15:0] req_addr, req_wdata, resp_data;
  logic [15:0] mem_A, mem_WW, mem_W;
  logic [7:0]  mem_WB, mem_B;
  logic [1:0]  mem_MW;

  load_store_unit #(.ADDR_W(16), .UNALIGNED_EN(UNALIGNED_EN)) dut (
    .C(C), .R(R),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .mem_A(mem_A), .mem_WW(mem_WW), .mem_WB(mem_WB), .mem_MW(mem_MW),
    .mem_W(mem_W), .mem_B(mem_B)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic       init_pending;

  function automatic logic [7:0] byte_init(input int i);
    return 8'((i * 29) ^ (i >> 8));
  endfunction

  // Memory block model: combinational reads, writes on the rising edge.
  assign mem_W = {mem[mem_A + 16'd1], mem[mem_A]};
  assign mem_B = mem[mem_A];

  always @(posedge C) begin
    if (init_pending) begin
      for (int i = 0; i < 65536; i++) mem[i] <= byte_init(i);
    end else if (mem_MW == 2'b10) begin
      mem[mem_A]         <= mem_WW[7:0];
      mem[mem_A + 16'd1] <= mem_WW[15:8];
    end else if (mem_MW == 2'b01) begin
      mem[mem_A] <= mem_WB;
    end
  end

  int          n_checks = 0;
  int          n_errors = 0;
  int          mw10_cnt, mw11_cnt;
  logic [23:0] sb_log[$];

  always @(negedge C) begin
    if (mem_MW == 2'b10) mw10_cnt++;
    if (mem_MW == 2'b11) mw11_cnt++;
    if (mem_MW == 2'b01) sb_log.push_back({mem_A, mem_WB});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request, compare against the reference model, optionally stall
  // the response for 'stall' cycles before accepting it.
  task automatic do_op(input logic [2:0] op, input logic [15:0] addr,
                       input logic [15:0] wd, input int stall);
    logic [15:0] a1, exp_data;
    logic        exp_err, unal;
    int          exp_lat, exp_w10, exp_w01, lat;
    a1       = addr + 16'd1;
    unal     = (op == 3'd0 || op == 3'd3) && addr[0];
    exp_err  = (op > 3'd4) || (unal && !UNALIGNED_EN);
    exp_data = 16'h0000;
    exp_lat  = exp_err ? 1 : (unal ? 3 : 2);
    exp_w10  = 0;
    exp_w01  = 0;
    if (!exp_err) begin
      case (op)
        3'd0: exp_data = {ref_mem[a1], ref_mem[addr]};
        3'd1: exp_data = {{8{ref_mem[addr][7]}}, ref_mem[addr]};
        3'd2: exp_data = {8'h00, ref_mem[addr]};
        3'd3: begin
          ref_mem[addr] = wd[7:0];
          ref_mem[a1]   = wd[15:8];
          if (unal) exp_w01 = 2; else exp_w10 = 1;
        end
        3'd4: begin
          ref_mem[addr] = wd[7:0];
          exp_w01 = 1;
        end
        default: ;
      endcase
    end

    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    mw10_cnt = 0;
    mw11_cnt = 0;
    sb_log.delete();
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge C);
    @(negedge C);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge C);
      lat++;
      @(negedge C);
    end
    check("resp_valid_seen", {31'd0, resp_valid}, 32'd1);
    check("latency", lat, exp_lat);
    check("resp_data", {16'd0, resp_data}, {16'd0, exp_data});
    check("resp_err", {31'd0, resp_err}, {31'd0, exp_err});

    for (int s = 0; s < stall; s++) begin
      @(posedge C);
      @(negedge C);
      check("stall_valid", {31'd0, resp_valid}, 32'd1);
      check("stall_data", {16'd0, resp_data}, {16'd0, exp_data});
      check("stall_ready", {31'd0, req_ready}, 32'd0);
    end

    resp_ready = 1'b1;
    @(posedge C);
    @(negedge C);
    resp_ready = 1'b0;
    check("resp_dropped", {31'd0, resp_valid}, 32'd0);
    check("zero_bubble", {31'd0, req_ready}, 32'd1);
    check("mw10_cycles", mw10_cnt, exp_w10);
    check("mw01_cycles", sb_log.size(), exp_w01);
    check("mw11_never", mw11_cnt, 0);
  endtask

  initial begin
    int diffs;
    logic [2:0]  rop;
    logic [15:0] raddr;

    for (int i = 0; i < 65536; i++) ref_mem[i] = byte_init(i);
    init_pending = 1'b1;
    R          = 1'b0;
    req_valid  = 1'b0;
    req_op     = 3'd0;
    req_addr   = 16'h0000;
    req_wdata  = 16'h0000;
    resp_ready = 1'b0;
    repeat (3) @(posedge C);
    @(negedge C);
    init_pending = 1'b0;
    check("rst_mem_A", {16'd0, mem_A}, 32'd0);
    check("rst_mem_WW", {16'd0, mem_WW}, 32'd0);
    check("rst_mem_WB", {24'd0, mem_WB}, 32'd0);
    check("rst_mem_MW", {30'd0, mem_MW}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", {16'd0, resp_data}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    R = 1'b1;
    @(negedge C);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // 1: SB then LB at byte 0
    do_op(3'd4, 16'h0000, 16'h000F, 0);
    check("t1_mem0", {24'd0, mem[0]}, 32'h0F);
    do_op(3'd1, 16'h0000, 16'h0000, 0);
    // 2: aligned SW/LW
    do_op(3'd3, 16'h0006, 16'h000A, 0);
    do_op(3'd0, 16'h0006, 16'h0000, 0);
    // 3: sign vs zero extension
    do_op(3'd4, 16'h0001, 16'h0080, 0);
    do_op(3'd1, 16'h0001, 16'h0000, 0);
    do_op(3'd2, 16'h0001, 16'h0000, 0);
    // 4: unaligned word split and address wrap
    do_op(3'd3, 16'h0003, 16'hBEEF, 0);
    check("t4_byte0", {8'd0, sb_log[0]}, {8'd0, 16'h0003, 8'hEF});
    check("t4_byte1", {8'd0, sb_log[1]}, {8'd0, 16'h0004, 8'hBE});
    do_op(3'd0, 16'h0003, 16'h0000, 0);
    do_op(3'd3, 16'hFFFF, 16'h1234, 0);
    check("t4_wrap", {8'd0, sb_log[1]}, {8'd0, 16'h0000, 8'h12});
    // 5: long stall, illegal op
    do_op(3'd0, 16'h0006, 16'h0000, 5);
    do_op(3'd7, 16'h0010, 16'hFFFF, 2);

    // 6: reset during ACC2 of an unaligned SW
    req_valid = 1'b1;
    req_op    = 3'd3;
    req_addr  = 16'h0011;
    req_wdata = 16'hA55A;
    @(posedge C);
    @(negedge C);
    req_valid = 1'b0;
    ref_mem[16'h0011] = 8'h5A;
    @(posedge C);
    @(negedge C);
    check("t6_in_acc2", {14'd0, mem_A, mem_MW}, {14'd0, 16'h0012, 2'b01});
    R = 1'b0;
    #1;
    check("t6_mw_forced", {30'd0, mem_MW}, 32'd0);
    @(posedge C);
    @(negedge C);
    check("t6_byte_lo", {24'd0, mem[16'h0011]}, 32'h5A);
    check("t6_byte_hi", {24'd0, mem[16'h0012]}, {24'd0, ref_mem[16'h0012]});
    check("t6_no_resp", {31'd0, resp_valid}, 32'd0);
    R = 1'b1;
    @(negedge C);
    check("t6_ready", {31'd0, req_ready}, 32'd1);

    // random traffic over a small window plus the top-of-memory wrap region
    for (int n = 0; n < 300; n++) begin
      rop   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      raddr = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                          : 16'($urandom_range(0, 31));
      do_op(rop, raddr, 16'($urandom), $urandom_range(0, 3));
    end

    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_final", diffs, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
